// File: rtl/uninasoc_pkg.sv
// Shared UninaSoC definitions: PLIC sizing, claim/complete ID type, the
// static platform interrupt line map and the PLIC claim FSM state type.
// No ports.
package uninasoc_pkg;

  localparam int unsigned PLIC_NUM_SOURCES = 32;
  localparam int unsigned PLIC_ID_WIDTH    = 5;
  localparam int unsigned PLIC_PRIO_WIDTH  = 3;

  typedef logic [PLIC_ID_WIDTH-1:0] plic_id_t;

  // Static platform interrupt line mapping (remaining lines are spare)
  localparam int unsigned PLIC_RESERVED_INTERRUPT = 0;
  localparam int unsigned PLIC_GPIOIN_INTERRUPT   = 1;
  localparam int unsigned PLIC_TIM0_INTERRUPT     = 2;
  localparam int unsigned PLIC_TIM1_INTERRUPT     = 3;
  localparam int unsigned PLIC_UART_INTERRUPT     = 4;

  typedef enum logic [0:0] {
    PLIC_IDLE = 1'b0,
    PLIC_RESP = 1'b1
  } plic_claim_state_e;

endpackage

// File: rtl/uninasoc_plic_gateway.sv
// Level gateway for one interrupt source: pending/in-flight pair.
//   clock_i, reset_i : clock, synchronous active-high reset
//   src_i            : level interrupt line
//   claim_i          : this source is being claimed (clears pending, sets in-flight)
//   complete_i       : this source is being completed (clears in-flight)
//   pending_o        : pending bit
module uninasoc_plic_gateway (
  input  logic clock_i,
  input  logic reset_i,
  input  logic src_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic pending_o
);

  logic pending_q, pending_d;
  logic inflight_q, inflight_d;

  always_comb begin
    pending_d = pending_q;
    if (claim_i) begin
      pending_d = 1'b0;
    end else if (src_i && !pending_q && !inflight_q) begin
      pending_d = 1'b1;
    end

    // Complete takes priority so a same-cycle claim+complete leaves nothing in flight
    inflight_d = inflight_q;
    if (claim_i) begin
      inflight_d = 1'b1;
    end
    if (complete_i) begin
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pending_q  <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/uninasoc_plic_target.sv
// Platform interrupt receiver/forwarder for a single target (the core).
// Per-source level gateways, registered arbitration, PLIC-style
// claim/complete handshake, registered external-interrupt output.
// Optional priority/threshold arbitration: define UNINASOC_PLIC_PRIORITY_EN.
//   clock_i, reset_i         : clock, synchronous active-high reset
//   irq_src_i, enable_i      : level interrupt lines, per-source enables
//   claim_req_i              : one-cycle claim request
//   claim_valid_o/claim_id_o : claim response strobe and ID (0 = none)
//   complete_valid_i/_id_i   : completion strobe and ID
//   ext_irq_o                : to core external-interrupt input
//   pending_o                : pending bits for read-back
//   prio_i, threshold_i      : per-source priority, target threshold (feature only)
module uninasoc_plic_target
  import uninasoc_pkg::*;
#(
  parameter int unsigned NUM_SOURCES = PLIC_NUM_SOURCES,
  parameter int unsigned ID_WIDTH    = $clog2(NUM_SOURCES),
  parameter int unsigned PRIO_WIDTH  = PLIC_PRIO_WIDTH
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic [NUM_SOURCES-1:0] irq_src_i,
  input  logic [NUM_SOURCES-1:0] enable_i,
  input  logic                   claim_req_i,
  output logic                   claim_valid_o,
  output logic [ID_WIDTH-1:0]    claim_id_o,
  input  logic                   complete_valid_i,
  input  logic [ID_WIDTH-1:0]    complete_id_i,
  output logic                   ext_irq_o,
  output logic [NUM_SOURCES-1:0] pending_o
`ifdef UNINASOC_PLIC_PRIORITY_EN
  ,
  input  logic [NUM_SOURCES*PRIO_WIDTH-1:0] prio_i,
  input  logic [PRIO_WIDTH-1:0]             threshold_i
`endif
);

  logic [NUM_SOURCES-1:1] pending;
  logic [NUM_SOURCES-1:1] eligible;
  logic [NUM_SOURCES-1:1] claim_hit;
  logic [NUM_SOURCES-1:1] complete_hit;
  logic                   claim_fire;

  logic [ID_WIDTH-1:0]    best_id_q, best_id_d;
  logic                   ext_irq_q, ext_irq_d;
  plic_claim_state_e      state_q, state_d;
  logic                   claim_valid_q, claim_valid_d;
  logic [ID_WIDTH-1:0]    claim_id_q, claim_id_d;

  // Line 0 is reserved and has no gateway
  logic unused_src0;
  assign unused_src0 = irq_src_i[0] ^ enable_i[0];

  // Claims use best_id_q, which is at most one cycle stale; pending[id] is
  // guaranteed still set because a claim cannot retire until after RESP.
  assign claim_fire = (state_q == PLIC_IDLE) && claim_req_i;

  always_comb begin
    claim_hit    = '0;
    complete_hit = '0;
    for (int unsigned s = 1; s < NUM_SOURCES; s++) begin
      claim_hit[s]    = claim_fire && (best_id_q == ID_WIDTH'(s));
      complete_hit[s] = complete_valid_i && (complete_id_i == ID_WIDTH'(s));
    end
  end

  for (genvar s = 1; s < NUM_SOURCES; s++) begin : g_gateway
    uninasoc_plic_gateway u_gateway (
      .clock_i    (clock_i),
      .reset_i    (reset_i),
      .src_i      (irq_src_i[s]),
      .claim_i    (claim_hit[s]),
      .complete_i (complete_hit[s]),
      .pending_o  (pending[s])
    );
  end

  assign pending_o = {pending, 1'b0};

`ifdef UNINASOC_PLIC_PRIORITY_EN
  logic [PRIO_WIDTH-1:0] best_prio;
  logic                  unused_prio0;
  assign unused_prio0 = ^prio_i[PRIO_WIDTH-1:0];

  // Highest priority wins; strict '>' keeps the lowest ID on ties
  always_comb begin
    eligible  = '0;
    best_prio = '0;
    best_id_d = '0;
    for (int unsigned s = 1; s < NUM_SOURCES; s++) begin
      eligible[s] = pending[s] && enable_i[s] &&
                    (prio_i[s*PRIO_WIDTH +: PRIO_WIDTH] > threshold_i);
      if (eligible[s] && (prio_i[s*PRIO_WIDTH +: PRIO_WIDTH] > best_prio)) begin
        best_prio = prio_i[s*PRIO_WIDTH +: PRIO_WIDTH];
        best_id_d = ID_WIDTH'(s);
      end
    end
  end
`else
  logic [PRIO_WIDTH-1:0] unused_prio_cfg;
  assign unused_prio_cfg = '0;

  always_comb begin
    eligible  = '0;
    best_id_d = '0;
    for (int unsigned s = 1; s < NUM_SOURCES; s++) begin
      eligible[s] = pending[s] && enable_i[s];
      if (eligible[s] && (best_id_d == '0)) begin
        best_id_d = ID_WIDTH'(s);
      end
    end
  end
`endif

  assign ext_irq_d = (best_id_d != '0);

  always_comb begin
    state_d       = state_q;
    claim_valid_d = 1'b0;
    claim_id_d    = '0;
    case (state_q)
      PLIC_IDLE: begin
        if (claim_req_i) begin
          state_d       = PLIC_RESP;
          claim_valid_d = 1'b1;
          claim_id_d    = best_id_q;
        end
      end
      PLIC_RESP: state_d = PLIC_IDLE;
      default:   state_d = PLIC_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= PLIC_IDLE;
      claim_valid_q <= 1'b0;
      claim_id_q    <= '0;
      best_id_q     <= '0;
      ext_irq_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      claim_valid_q <= claim_valid_d;
      claim_id_q    <= claim_id_d;
      best_id_q     <= best_id_d;
      ext_irq_q     <= ext_irq_d;
    end
  end

  assign claim_valid_o = claim_valid_q;
  assign claim_id_o    = claim_id_q;
  assign ext_irq_o     = ext_irq_q;

endmodule

// File: tb/tb_uninasoc_plic_target.sv
// Self-checking bench for uninasoc_plic_target. Expected claim IDs are
// queued when a claim is issued and compared when claim_valid_o fires.
module tb_uninasoc_plic_target;
  import uninasoc_pkg::*;

  localparam int unsigned NS  = PLIC_NUM_SOURCES;
  localparam int unsigned IDW = PLIC_ID_WIDTH;
  localparam int unsigned PW  = PLIC_PRIO_WIDTH;

  logic            clk = 1'b0;
  logic            rst;
  logic [NS-1:0]   src;
  logic [NS-1:0]   en;
  logic            creq;
  logic            cvalid;
  logic [IDW-1:0]  cid;
  logic            claim_valid_o;
  logic [IDW-1:0]  claim_id_o;
  logic            ext_irq_o;
  logic [NS-1:0]   pending_o;
`ifdef UNINASOC_PLIC_PRIORITY_EN
  logic [NS*PW-1:0] prio;
  logic [PW-1:0]    thr;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  plic_id_t    exp_q[$];

  always #5 clk = ~clk;

  uninasoc_plic_target #(
    .NUM_SOURCES (NS),
    .ID_WIDTH    (IDW),
    .PRIO_WIDTH  (PW)
  ) dut (
    .clock_i          (clk),
    .reset_i          (rst),
    .irq_src_i        (src),
    .enable_i         (en),
    .claim_req_i      (creq),
    .claim_valid_o    (claim_valid_o),
    .claim_id_o       (claim_id_o),
    .complete_valid_i (cvalid),
    .complete_id_i    (cid),
    .ext_irq_o        (ext_irq_o),
    .pending_o        (pending_o)
`ifdef UNINASOC_PLIC_PRIORITY_EN
    ,
    .prio_i           (prio),
    .threshold_i      (thr)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every response strobe must match a queued claim
  always @(negedge clk) begin
    if (claim_valid_o === 1'b1) begin
      if (exp_q.size() > 0) check_eq("claim_id", 32'(claim_id_o), 32'(exp_q.pop_front()));
      else                  check_eq("claim_unexpected", 32'(claim_valid_o), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_claim(input plic_id_t exp_id);
    exp_q.push_back(exp_id);
    creq = 1'b1;
    step();
    creq = 1'b0;
    check_eq("claim_valid_n1", 32'(claim_valid_o), 32'd1);
    step();
    check_eq("claim_valid_drop", 32'(claim_valid_o), 32'd0);
    check_eq("claim_id_idle", 32'(claim_id_o), 32'd0);
    check_eq("sb_drain", exp_q.size(), 32'd0);
  endtask

  task automatic do_complete(input plic_id_t id);
    cvalid = 1'b1;
    cid    = id;
    step();
    cvalid = 1'b0;
    cid    = '0;
  endtask

  task automatic bit_mask(input int unsigned idx, output logic [NS-1:0] m);
    m = '0;
    m[idx] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NS-1:0] m_uart, m_gpio, m_t0, m_t1, m7, m9, m0;
    bit_mask(PLIC_UART_INTERRUPT, m_uart);
    bit_mask(PLIC_GPIOIN_INTERRUPT, m_gpio);
    bit_mask(PLIC_TIM0_INTERRUPT, m_t0);
    bit_mask(PLIC_TIM1_INTERRUPT, m_t1);
    bit_mask(PLIC_RESERVED_INTERRUPT, m0);
    bit_mask(7, m7);
    bit_mask(9, m9);

    rst = 1'b1; src = '0; en = '0; creq = 1'b0; cvalid = 1'b0; cid = '0;
`ifdef UNINASOC_PLIC_PRIORITY_EN
    for (int unsigned s = 0; s < NS; s++) prio[s*PW +: PW] = PW'(1);
    thr = '0;
`endif
    step(); step();
    check_eq("rst_pending", pending_o, 32'd0);
    check_eq("rst_ext", 32'(ext_irq_o), 32'd0);
    check_eq("rst_cvalid", 32'(claim_valid_o), 32'd0);
    check_eq("rst_cid", 32'(claim_id_o), 32'd0);
    rst = 1'b0;
    step();

    // UART: level held, claim, completion with source still high
    en = m_uart; src = m_uart;
    step();
    check_eq("uart_pend", pending_o, m_uart);
    check_eq("uart_ext_early", 32'(ext_irq_o), 32'd0);
    step();
    check_eq("uart_ext", 32'(ext_irq_o), 32'd1);
    do_claim(plic_id_t'(PLIC_UART_INTERRUPT));
    check_eq("uart_pend_clr", pending_o, 32'd0);
    check_eq("uart_ext_drop", 32'(ext_irq_o), 32'd0);
    step(); step(); step();
    check_eq("uart_inflight_pend", pending_o, 32'd0);
    check_eq("uart_inflight_ext", 32'(ext_irq_o), 32'd0);
    do_complete(plic_id_t'(PLIC_UART_INTERRUPT));
    check_eq("uart_cpl_edge", pending_o, 32'd0);
    step();
    check_eq("uart_repend", pending_o, m_uart);
    src = '0;
    step();
    check_eq("uart_repend_ext", 32'(ext_irq_o), 32'd1);
    do_claim(plic_id_t'(PLIC_UART_INTERRUPT));
    do_complete(plic_id_t'(PLIC_UART_INTERRUPT));
    step();
    check_eq("uart_clean", pending_o, 32'd0);

    // TIM0 + TIM1 pulsed together; claim held into RESP is ignored
    en = m_t0 | m_t1; src = m_t0 | m_t1;
    step();
    src = '0;
    check_eq("tim_pend", pending_o, m_t0 | m_t1);
    step();
    exp_q.push_back(plic_id_t'(PLIC_TIM0_INTERRUPT));
    creq = 1'b1;
    step();
    check_eq("tim_resp", 32'(claim_valid_o), 32'd1);
    step();
    creq = 1'b0;
    check_eq("tim_resp_ignored", 32'(claim_valid_o), 32'd0);
    check_eq("tim_sb", exp_q.size(), 32'd0);
    do_claim(plic_id_t'(PLIC_TIM1_INTERRUPT));
    do_claim('0);
    check_eq("tim_ext_none", 32'(ext_irq_o), 32'd0);
    do_complete(plic_id_t'(PLIC_TIM0_INTERRUPT));
    do_complete(plic_id_t'(PLIC_TIM1_INTERRUPT));
    step();
    check_eq("tim_clean", pending_o, 32'd0);

    // GPIO-in disabled: pending kept, no interrupt until enabled
    en = '0; src = m_gpio;
    step(); step(); step();
    check_eq("gpio_pend_dis", pending_o, m_gpio);
    check_eq("gpio_ext_dis", 32'(ext_irq_o), 32'd0);
    en = m_gpio;
    step();
    check_eq("gpio_ext_en", 32'(ext_irq_o), 32'd1);
    do_claim(plic_id_t'(PLIC_GPIOIN_INTERRUPT));
    src = '0;
    do_complete(plic_id_t'(PLIC_GPIOIN_INTERRUPT));
    step();
    check_eq("gpio_clean", pending_o, 32'd0);

    // Reserved line, complete of ID 0 and of a non-in-flight ID
    en = '1; src = m7;
    step();
    src = m0;
    do_complete('0);
    do_complete(plic_id_t'(7));
    step();
    check_eq("bad_cpl_pend", pending_o, m7);
    check_eq("bad_cpl_ext", 32'(ext_irq_o), 32'd1);
    do_claim(plic_id_t'(7));
    src = '0;
    do_complete(plic_id_t'(7));
    step();
    check_eq("bad_cpl_clean", pending_o, 32'd0);

    // Same-cycle claim and complete of one ID: nothing left in flight
    en = m9; src = m9;
    step(); step();
    exp_q.push_back(plic_id_t'(9));
    creq = 1'b1; cvalid = 1'b1; cid = plic_id_t'(9);
    step();
    creq = 1'b0; cvalid = 1'b0; cid = '0;
    check_eq("cc_valid", 32'(claim_valid_o), 32'd1);
    check_eq("cc_pend", pending_o, 32'd0);
    step();
    check_eq("cc_repend", pending_o, m9);
    src = '0;
    step();
    do_claim(plic_id_t'(9));
    do_complete(plic_id_t'(9));

    // Reset arriving with a claim in progress
    en = m_uart | m_t0; src = m_uart;
    step(); step();
    do_claim(plic_id_t'(PLIC_UART_INTERRUPT));
    src = m_uart | m_t0;
    step(); step();
    creq = 1'b1; rst = 1'b1;
    step();
    check_eq("rstc_valid", 32'(claim_valid_o), 32'd0);
    check_eq("rstc_pend", pending_o, 32'd0);
    check_eq("rstc_ext", 32'(ext_irq_o), 32'd0);
    rst = 1'b0; creq = 1'b0;
    step();
    check_eq("rstc_inflight_clr", pending_o, m_uart | m_t0);
    src = '0; rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check_eq("rstc_clean", pending_o, 32'd0);

`ifdef UNINASOC_PLIC_PRIORITY_EN
    prio[PLIC_TIM0_INTERRUPT*PW +: PW] = PW'(1);
    prio[PLIC_TIM1_INTERRUPT*PW +: PW] = PW'(5);
    thr = PW'(1);
    en = m_t0 | m_t1; src = m_t0 | m_t1;
    step();
    src = '0;
    step();
    check_eq("prio_ext", 32'(ext_irq_o), 32'd1);
    thr = PW'(5);
    step();
    check_eq("prio_thr_mask", 32'(ext_irq_o), 32'd0);
    thr = PW'(1);
    step();
    do_claim(plic_id_t'(PLIC_TIM1_INTERRUPT));
    check_eq("prio_low_masked", 32'(ext_irq_o), 32'd0);
    thr = '0;
    step(); step();
    check_eq("prio_low_ext", 32'(ext_irq_o), 32'd1);
    do_claim(plic_id_t'(PLIC_TIM0_INTERRUPT));
    do_complete(plic_id_t'(PLIC_TIM0_INTERRUPT));
    do_complete(plic_id_t'(PLIC_TIM1_INTERRUPT));
`endif

    step();
    check_eq("final_sb", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uninasoc_plic_target.md
Name: uninasoc_plic_target

Overview:
- Platform-interrupt receiver and forwarder.
- Collects the 32 statically mapped platform interrupt lines: line 0 reserved, 1 GPIO-in, 2 TIM0, 3 TIM1, 4 UART, rest spare.
- Each line passes through a level gateway, then arbitration; the result drives the core's external-interrupt input (mcause 11).
- The core side uses a PLIC-style claim/complete handshake; the register front-end (AXI-Lite slave on PBUS) is a separate block.

Parameters:
- NUM_SOURCES, 32, interrupt lines including reserved line 0.
- ID_WIDTH, $clog2(NUM_SOURCES) = 5, width of claim/complete IDs.
- PRIO_WIDTH, 3, priority width; used only when the optional feature is enabled.

Ports:
- clock_i  in  1  system clock.
- reset_i  in  1  synchronous, active-high reset.
- irq_src_i  in  NUM_SOURCES  level interrupt lines, already synchronous to clock_i.
- enable_i  in  NUM_SOURCES  per-source enable.
- claim_req_i  in  1  one-cycle claim request.
- claim_valid_o  out  1  claim response strobe.
- claim_id_o  out  ID_WIDTH  claimed ID; 0 means none.
- complete_valid_i  in  1  completion strobe.
- complete_id_i  in  ID_WIDTH  ID being completed.
- ext_irq_o  out  1  to core external-interrupt input.
- pending_o  out  NUM_SOURCES  pending bits, for read-back.
- prio_i  in  NUM_SOURCES*PRIO_WIDTH  per-source priority [feature only].
- threshold_i  in  PRIO_WIDTH  target threshold [feature only].

Behaviour:
- Reset: pending, in-flight, best_id_q, claim_valid_o, claim_id_o and ext_irq_o all 0; FSM in IDLE.
- Gateway, per source s ≥ 1:
  - pending[s] sets when irq_src_i[s]=1 and pending[s]=0 and inflight[s]=0.
  - The enable does not gate pending.
  - Source 0 is hardwired: pending[0]=inflight[0]=0.
- Arbitration:
  - eligible[s] = pending[s] & enable_i[s].
  - best_id_q is registered each cycle and holds the lowest eligible index, or 0 if none.
  - ext_irq_o is registered: ext_irq_o = (next best_id != 0). It rises one cycle after the pending bit is visible.
- Claim FSM states: IDLE, RESP.
  - IDLE + claim_req_i → RESP. Capture id = best_id_q. If id != 0, clear pending[id] and set inflight[id] in the same edge.
  - RESP: claim_valid_o=1 and claim_id_o=id for exactly one cycle, then → IDLE. claim_id_o returns to 0 outside RESP.
  - Latency: request at cycle N → response at N+1.
  - claim_req_i asserted while in RESP is ignored.
- Complete:
  - complete_valid_i with a valid ID clears inflight[id] on that edge.
  - ID 0, an ID ≥ NUM_SOURCES, or an ID not in flight: ignored.
  - If the source is still high after completion, pending re-sets on the next cycle.
- Simultaneous events:
  - Claim and complete of the same ID in one cycle: the claim uses the old pending; the complete clears inflight. Result: inflight=0, pending=0.
  - Gateway set and claim clear on the same source in one cycle: the claim clear wins. This cannot occur while inflight is 0 and pending is 1.
  - Rising source while inflight: no new pending until complete.
- Enable deassert: the pending bit is kept; the source only drops out of arbitration.
- Reset mid-claim: FSM returns to IDLE, no response strobe, all state cleared.

Optional Feature:
- Macro: UNINASOC_PLIC_PRIORITY_EN.
- With the macro:
  - eligible[s] additionally requires prio_i[s] > threshold_i; priority 0 never interrupts.
  - The winner is the highest priority; ties go to the lowest ID.
  - The arbitration tree stays registered, same latency.
- Without the macro:
  - prio_i and threshold_i ports are absent.
  - Fixed lowest-ID-wins arbitration.

Decomposition:
- In uninasoc_pkg, add:
  - PLIC_NUM_SOURCES=32, PLIC_ID_WIDTH=5, PLIC_PRIO_WIDTH=3.
  - typedef plic_id_t.
  - The existing PLIC_*_INTERRUPT line constants, reused for mapping.
- One sub-module, uninasoc_plic_gateway: a single-source pending/inflight pair with set, claim and complete inputs. Instantiated NUM_SOURCES-1 times.

Test Plan:
- Hold irq_src_i[4] (UART) high with enable_i[4]=1 → ext_irq_o=1 two cycles later. Claim → claim_id_o=4 at N+1. Pending[4]=0 and ext_irq_o drops, with no re-assert while in flight. Complete 4 with source still high → pending[4] re-sets the next cycle.
- Pulse sources 2 and 3 in the same cycle, both enabled → first claim returns 2, second returns 3, third returns 0 with claim_valid_o=1.
- enable_i[1]=0 with irq_src_i[1] high → pending_o[1]=1 and ext_irq_o=0. Raise enable → ext_irq_o=1 next cycle.
- Drive irq_src_i[0]=1, complete_id_i=0, and complete of a non-in-flight ID 7 → no state change.
- Assert reset_i in the cycle after claim_req_i → no claim_valid_o; pending, inflight and ext_irq_o all 0.
- [UNINASOC_PLIC_PRIORITY_EN] prio[2]=1, prio[3]=5, threshold=1, both pending → claim returns 3. Then threshold=5 → ext_irq_o=0.
